song_sequencer: RTL and testbench

- Auto-play controller for the organ's tone generator.
- Steps through a song table held in an external ROM: one entry per note, giving note, octave and duration in ticks.
- Drives the value_play/tone_play inputs of the frequency divider, and its `state` source-select line.
- Handles start/stop/pause/loop; a pressed keyboard key temporarily takes the tone generator back from playback.

---
 rtl/organ_pkg.sv | 30 +++
 rtl/song_sequencer_if.sv | 30 +++
 rtl/tick_gen.sv | 29 ++
 rtl/song_sequencer.sv | 129 ++++++++++++
 tb/tb_song_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/organ_pkg.sv
// Shared definitions for the organ auto-play path: note/tone codes, song ROM
// field layout and the sequencer state encoding.
package organ_pkg;

  localparam logic [2:0] NOTE_REST = 3'd0;

  localparam logic [1:0] TONE_LOW  = 2'b00;
  localparam logic [1:0] TONE_MID1 = 2'b01;
  localparam logic [1:0] TONE_MID2 = 2'b10;
  localparam logic [1:0] TONE_HIGH = 2'b11;

  localparam int unsigned ROM_W    = 9;
  localparam int unsigned VAL_LSB  = 6;
  localparam int unsigned VAL_W    = 3;
  localparam int unsigned TONE_LSB = 4;
  localparam int unsigned TONE_W   = 2;
  localparam int unsigned DUR_LSB  = 0;
  localparam int unsigned DUR_W    = 4;

  localparam logic [DUR_W-1:0] END_DUR = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_NOTE,
    ST_GAP,
    ST_PAUSED
  } seq_state_t;

endpackage

// File: rtl/song_sequencer_if.sv
// Control, song ROM and tone-generator signals of the song sequencer.
interface song_sequencer_if #(
  parameter int unsigned ADDR_W = 6
);
  import organ_pkg::*;

  logic                play;
  logic                stop;
  logic                pause_tog;
  logic                loop_en;
  logic                key_active;
  logic [ADDR_W-1:0]   rom_addr;
  logic [ROM_W-1:0]    rom_data;
  logic [VAL_W-1:0]    value_play;
  logic [TONE_W-1:0]   tone_play;
  logic                state;
  logic                busy;
  logic                song_done;

  modport master (
    output play, stop, pause_tog, loop_en, key_active, rom_data,
    input  rom_addr, value_play, tone_play, state, busy, song_done
  );

  modport slave (
    input  play, stop, pause_tog, loop_en, key_active, rom_data,
    output rom_addr, value_play, tone_play, state, busy, song_done
  );

endinterface

// File: rtl/tick_gen.sv
// Enable-gated, clearable modulo-TICK_DIV counter; o_tick marks the enabled
// cycle on which the count wraps.
module tick_gen #(
  parameter int unsigned TICK_DIV = 6250000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);
  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/song_sequencer.sv
// Auto-play controller: walks the song ROM and feeds note/octave to the tone
// generator, with pause, loop and keyboard override.
module song_sequencer
  import organ_pkg::*;
#(
  parameter int unsigned TICK_DIV = 6250000,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  song_sequencer_if.slave   bus
);

  seq_state_t          r_st, w_nxt, r_saved;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic [DUR_W-1:0]    r_rem;
  logic [VAL_W-1:0]    r_note;
  logic [TONE_W-1:0]   r_tone;
  logic                r_done;
  logic                r_state;
  logic                w_busy, w_frz, w_ev, w_en, w_clr, w_tick, w_end;
  logic [VAL_W-1:0]    w_value;
  logic [VAL_W-1:0]    w_rom_val;
  logic [TONE_W-1:0]   w_rom_tone;
  logic [DUR_W-1:0]    w_rom_dur;

  assign w_rom_val  = bus.rom_data[VAL_LSB  +: VAL_W];
  assign w_rom_tone = bus.rom_data[TONE_LSB +: TONE_W];
  assign w_rom_dur  = bus.rom_data[DUR_LSB  +: DUR_W];

  // Any external event blocks the internal advance on the same cycle.
  assign w_frz = bus.key_active & w_busy;
  assign w_ev  = bus.stop | bus.play | (bus.pause_tog & w_busy);
  assign w_en  = ((r_st == ST_NOTE) || (r_st == ST_GAP)) & ~w_frz & ~w_ev;
  assign w_clr = (r_st == ST_FETCH) | bus.stop | bus.play;
  assign w_end = (r_rom_addr == '1);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_en),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_st <= ST_IDLE;
    else     r_st <= w_nxt;
  end

  always_comb begin
    w_nxt = r_st;
    if (bus.stop) begin
      w_nxt = ST_IDLE;
    end else if (bus.play) begin
      w_nxt = ST_FETCH;
    end else if (bus.pause_tog && w_busy) begin
      w_nxt = (r_st == ST_PAUSED) ? r_saved : ST_PAUSED;
    end else if (!w_frz) begin
      case (r_st)
        ST_FETCH: begin
          if (w_rom_dur == END_DUR) w_nxt = bus.loop_en ? ST_FETCH : ST_IDLE;
          else                      w_nxt = ST_NOTE;
        end
        ST_NOTE:  if (w_tick && r_rem == 4'd1) w_nxt = ST_GAP;
        ST_GAP: begin
          if (w_tick) w_nxt = (w_end && !bus.loop_en) ? ST_IDLE : ST_FETCH;
        end
        default:  w_nxt = r_st;
      endcase
    end
  end

  always_comb begin
    w_busy  = (r_st != ST_IDLE);
    w_value = NOTE_REST;
    if (r_st == ST_NOTE) w_value = r_note;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rom_addr <= '0;
      r_rem      <= '0;
      r_note     <= NOTE_REST;
      r_tone     <= TONE_LOW;
      r_saved    <= ST_IDLE;
      r_done     <= 1'b0;
      r_state    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_state <= w_busy & ~bus.key_active;
      if (bus.stop || bus.play) begin
        r_rom_addr <= '0;
      end else if (bus.pause_tog && w_busy) begin
        if (r_st != ST_PAUSED) r_saved <= r_st;
      end else if (!w_frz) begin
        case (r_st)
          ST_FETCH: begin
            if (w_rom_dur == END_DUR) begin
              if (bus.loop_en) r_rom_addr <= '0;
              else             r_done     <= 1'b1;
            end else begin
              r_note <= w_rom_val;
              r_tone <= w_rom_tone;
              r_rem  <= w_rom_dur;
            end
          end
          ST_NOTE: if (w_tick) r_rem <= r_rem - 1'b1;
          ST_GAP: begin
            if (w_tick) begin
              if (!w_end)            r_rom_addr <= r_rom_addr + 1'b1;
              else if (bus.loop_en)  r_rom_addr <= '0;
              else                   r_done     <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rom_addr   = r_rom_addr;
  assign bus.value_play = w_value;
  assign bus.tone_play  = r_tone;
  assign bus.state      = r_state;
  assign bus.busy       = w_busy;
  assign bus.song_done  = r_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with TICK_DIV=4, ADDR_W=3.
module tb_song_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [8:0] rom [0:7];

  int n_chk  = 0;
  int n_pass = 0;

  song_sequencer_if #(.ADDR_W(3)) bus ();

  song_sequencer #(.TICK_DIV(4), .ADDR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rom_data = rom[bus.rom_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_play();
    bus.play = 1'b1; step(); bus.play = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
  endtask

  task automatic seg(input string tag, input int n, input int val);
    for (int i = 0; i < n; i++) begin
      chk(tag, bus.value_play, val);
      chk({tag, "_busy"}, bus.busy, 1);
      chk({tag, "_done"}, bus.song_done, 0);
      step();
    end
  endtask

  function automatic logic [8:0] ent(input int v, input int t, input int d);
    return {3'(v), 2'(t), 4'(d)};
  endfunction

  task automatic load_short();
    for (int i = 0; i < 8; i++) rom[i] = '0;
    rom[0] = ent(1, 0, 2);
    rom[1] = ent(5, 2, 1);
    rom[2] = ent(0, 0, 0);
  endtask

  task automatic load_full();
    for (int i = 0; i < 8; i++) rom[i] = ent((i % 7) + 1, i % 4, 1);
  endtask

  initial begin
    bus.play = 1'b0; bus.stop = 1'b0; bus.pause_tog = 1'b0;
    bus.loop_en = 1'b0; bus.key_active = 1'b0;
    load_short();

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", bus.rom_addr, 0);
    chk("rst_val", bus.value_play, 0);
    chk("rst_tone", bus.tone_play, 0);
    chk("rst_state", bus.state, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.song_done, 0);
    rst = 1'b0;
    step();

    // basic song
    pulse_play();
    chk("t1_fetch_addr", bus.rom_addr, 0);
    seg("t1_fetch0", 1, 0);
    chk("t1_state", bus.state, 1);
    chk("t1_tone0", bus.tone_play, 0);
    seg("t1_note1", 8, 1);
    seg("t1_gap0", 4, 0);
    chk("t1_fetch1_addr", bus.rom_addr, 1);
    seg("t1_fetch1", 1, 0);
    chk("t1_tone1", bus.tone_play, 2);
    seg("t1_note5", 4, 5);
    seg("t1_gap1", 4, 0);
    chk("t1_fetch2_addr", bus.rom_addr, 2);
    seg("t1_fetch2", 1, 0);
    chk("t1_done", bus.song_done, 1);
    chk("t1_idle_busy", bus.busy, 0);
    chk("t1_idle_val", bus.value_play, 0);
    step();
    chk("t1_done_drop", bus.song_done, 0);
    chk("t1_state_drop", bus.state, 0);

    // looping
    bus.loop_en = 1'b1;
    pulse_play();
    for (int r = 0; r < 3; r++) begin
      chk("t2_loop_addr", bus.rom_addr, 0);
      seg("t2_fetch0", 1, 0);
      seg("t2_note1", 8, 1);
      seg("t2_gap0", 4, 0);
      seg("t2_fetch1", 1, 0);
      seg("t2_note5", 4, 5);
      seg("t2_gap1", 4, 0);
      chk("t2_end_addr", bus.rom_addr, 2);
      seg("t2_fetch2", 1, 0);
    end
    chk("t2_wrap_addr", bus.rom_addr, 0);
    bus.loop_en = 1'b0;
    pulse_stop();
    chk("t2_stop_busy", bus.busy, 0);
    chk("t2_stop_done", bus.song_done, 0);

    // pause mid-note
    pulse_play();
    seg("t3_fetch0", 1, 0);
    seg("t3_pre", 3, 1);
    bus.pause_tog = 1'b1;
    chk("t3_tog_val", bus.value_play, 1);
    step();
    bus.pause_tog = 1'b0;
    for (int i = 0; i < 19; i++) begin
      seg("t3_paused", 1, 0);
      chk("t3_paused_addr", bus.rom_addr, 0);
    end
    bus.pause_tog = 1'b1;
    seg("t3_resume_tog", 1, 0);
    bus.pause_tog = 1'b0;
    seg("t3_post", 5, 1);
    seg("t3_gap", 4, 0);
    chk("t3_next_addr", bus.rom_addr, 1);
    pulse_stop();

    // keyboard override
    pulse_play();
    seg("t4_fetch0", 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_state_pre", bus.state, 1);
      seg("t4_pre", 1, 1);
    end
    bus.key_active = 1'b1;
    chk("t4_state_lag", bus.state, 1);
    seg("t4_key0", 1, 1);
    for (int i = 0; i < 9; i++) begin
      chk("t4_state_key", bus.state, 0);
      seg("t4_key", 1, 1);
    end
    bus.key_active = 1'b0;
    chk("t4_state_rel_lag", bus.state, 0);
    seg("t4_rel0", 1, 1);
    chk("t4_state_back", bus.state, 1);
    seg("t4_post", 4, 1);
    seg("t4_gap", 4, 0);
    pulse_stop();

    // stop and play together
    pulse_play();
    seg("t5_fetch0", 1, 0);
    seg("t5_note1", 8, 1);
    seg("t5_gap0", 4, 0);
    seg("t5_fetch1", 1, 0);
    seg("t5_note5", 2, 5);
    chk("t5_pre_addr", bus.rom_addr, 1);
    bus.stop = 1'b1; bus.play = 1'b1;
    step();
    bus.stop = 1'b0; bus.play = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_idle_busy", bus.busy, 0);
      chk("t5_idle_addr", bus.rom_addr, 0);
      chk("t5_idle_val", bus.value_play, 0);
      chk("t5_idle_done", bus.song_done, 0);
      step();
    end
    pulse_play();
    chk("t5_restart_addr", bus.rom_addr, 0);
    seg("t5_restart_fetch", 1, 0);
    seg("t5_restart_note", 1, 1);
    pulse_stop();

    // full table, no end marker
    load_full();
    pulse_play();
    for (int i = 0; i < 8; i++) begin
      chk("t6_addr", bus.rom_addr, i);
      seg("t6_fetch", 1, 0);
      chk("t6_tone", bus.tone_play, i % 4);
      seg("t6_note", 4, (i % 7) + 1);
      seg("t6_gap", 4, 0);
    end
    chk("t6_done", bus.song_done, 1);
    chk("t6_busy", bus.busy, 0);
    step();
    bus.loop_en = 1'b1;
    pulse_play();
    for (int i = 0; i < 8; i++) begin
      seg("t6l_fetch", 1, 0);
      seg("t6l_note", 4, (i % 7) + 1);
      seg("t6l_gap", 4, 0);
    end
    chk("t6l_wrap_addr", bus.rom_addr, 0);
    chk("t6l_busy", bus.busy, 1);
    seg("t6l_fetch_again", 1, 0);
    seg("t6l_note_again", 1, 1);
    bus.loop_en = 1'b0;
    pulse_stop();

    // asynchronous reset mid-note
    pulse_play();
    seg("t7_fetch0", 1, 0);
    seg("t7_note0", 4, 1);
    seg("t7_gap0", 4, 0);
    seg("t7_fetch1", 1, 0);
    seg("t7_note1", 2, 2);
    chk("t7_pre_tone", bus.tone_play, 1);
    chk("t7_pre_addr", bus.rom_addr, 1);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_addr", bus.rom_addr, 0);
    chk("t7_rst_val", bus.value_play, 0);
    chk("t7_rst_tone", bus.tone_play, 0);
    chk("t7_rst_state", bus.state, 0);
    chk("t7_rst_busy", bus.busy, 0);
    chk("t7_rst_done", bus.song_done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("t7_after_busy", bus.busy, 0);
    chk("t7_after_done", bus.song_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
